// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the maxnet frame sequencer and its packer.
package maxnet_pkg;
  localparam int MAXNET_DW = 5;
  localparam int MAXNET_N  = 4;

  typedef logic [MAXNET_DW-1:0] sample_t;

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, HOLD} seq_state_t;
endpackage

// File: rtl/frame_packer.sv
// Collects N samples into slot registers in arrival order; flags a full frame
// until the sequencer releases it.
module frame_packer #(
  parameter int N  = 4,
  parameter int DW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            accept_i,
  input  logic            clr_i,
  input  logic [DW-1:0]   data_i,
  output logic [N*DW-1:0] frame_o,
  output logic            last_o,
  output logic            full_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0]          idx_q;
  logic                   full_q;
  logic [N-1:0][DW-1:0]   slot_q;

  assign last_o  = (idx_q == IW'(N-1));
  assign full_o  = full_q;
  assign frame_o = slot_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (accept_i) begin
      idx_q  <= last_o ? '0 : idx_q + 1'b1;
      full_q <= last_o;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (rst_i)                             slot_q[k] <= '0;
      else if (accept_i && idx_q == IW'(k))  slot_q[k] <= data_i;
    end
  end
endmodule

// File: rtl/maxnet_frame_sequencer.sv
// Wraps the maxnet core: packs N samples, launches the core, waits for done
// with a timeout guard, and returns the captured max over a valid/ready port.
module maxnet_frame_sequencer
  import maxnet_pkg::*;
#(
  parameter int DW      = MAXNET_DW,
  parameter int N       = MAXNET_N,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic [N*DW-1:0] x_out,
  output logic            start,
  input  logic            core_done,
  input  logic [DW-1:0]   core_max,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic            timeout_err,
  output logic [CNTW-1:0] frame_cnt
);
  localparam int WCW = $clog2(TIMEOUT) + 1;

  seq_state_t      state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic            tmo_q, tmo_d;
  logic [CNTW-1:0] fcnt_q, fcnt_d;
  logic            accept, clr, last, full;

  frame_packer #(.N(N), .DW(DW)) u_packer (
    .clk_i    (clock),
    .rst_i    (reset),
    .accept_i (accept),
    .clr_i    (clr),
    .data_i   (in_data),
    .frame_o  (x_out),
    .last_o   (last),
    .full_o   (full)
  );

  // Handshake outputs are decoded from registered state only.
  assign in_ready    = (state_q == FILL) && !full;
  assign start       = (state_q == LAUNCH);
  assign res_valid   = (state_q == HOLD);
  assign res_data    = res_data_q;
  assign timeout_err = tmo_q;
  assign frame_cnt   = fcnt_q;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    res_data_d = res_data_q;
    tmo_d      = tmo_q;
    fcnt_d     = fcnt_q;
    accept     = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      FILL: begin
        accept = in_valid && in_ready;
        if (accept && last) state_d = LAUNCH;
      end
      LAUNCH: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        // A done in the final timeout cycle still wins.
        if (core_done) begin
          res_data_d = core_max;
          fcnt_d     = fcnt_q + 1'b1;
          state_d    = HOLD;
        end else if (wcnt_q == WCW'(TIMEOUT-1)) begin
          tmo_d   = 1'b1;
          clr     = 1'b1;
          state_d = FILL;
        end
      end
      HOLD: begin
        if (res_ready) begin
          clr     = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      wcnt_q     <= '0;
      res_data_q <= '0;
      tmo_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      res_data_q <= res_data_d;
      tmo_q      <= tmo_d;
      fcnt_q     <= fcnt_d;
    end
  end
endmodule

// File: doc/maxnet_frame_sequencer.md
Name: maxnet_frame_sequencer

Overview:
Upstream/downstream wrapper stage for the 4-neuron maxnet core.
- Accepts a stream of 5-bit samples over a valid/ready handshake and packs four samples into a frame.
- Presents the packed frame to the core as x0..x3 and pulses start, then waits for the core's done.
- Captures the core's 5-bit max output and returns it on a valid/ready result port, with a timeout guard and a frame counter.

Parameters:
DW, 5, sample and result width; matches the core's x and max width.
N, 4, samples per frame; equals the core's neuron count.
TIMEOUT, 64, cycles allowed in WAIT before the frame is aborted.
CNTW, 8, frame-counter width.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  upstream sample valid.
in_ready  out  1  sample accepted when in_valid & in_ready.
in_data  in  DW  sample value.
x_out  out  N*DW  packed frame; sample k occupies bits [k*DW +: DW], k = arrival order.
start  out  1  one-cycle launch pulse to the core.
core_done  in  1  core completion.
core_max  in  DW  core result; sampled only in the cycle core_done=1 is seen in WAIT.
res_valid  out  1  result valid.
res_ready  in  1  result consumed when res_valid & res_ready.
res_data  out  DW  captured max.
timeout_err  out  1  sticky; set on abort, cleared only by reset.
frame_cnt  out  CNTW  count of completed frames; wraps modulo 2^CNTW.

Behaviour:
- Reset values: state=FILL, fill index=0, x_out=0, start=0, res_valid=0, res_data=0, timeout_err=0, frame_cnt=0, wait counter=0. Reset wins over every other event in the same cycle, including mid-WAIT.
- FILL:
  - in_ready=1.
  - On handshake, write in_data to slot idx and increment idx.
  - When the N-th sample is accepted (idx==N-1), go to LAUNCH next cycle with idx=0.
- LAUNCH:
  - in_ready=0.
  - start=1 for exactly this one cycle; x_out stays stable from here until the state returns to FILL.
  - Go to WAIT, clearing the wait counter.
- WAIT:
  - in_ready=0; the wait counter increments each cycle.
  - If core_done=1: res_data<=core_max, res_valid<=1, frame_cnt+=1 (wrap allowed), go to HOLD.
  - Else, when the counter reaches TIMEOUT-1: timeout_err<=1, go to FILL with idx=0, and no result is emitted.
  - If core_done and the timeout coincide, done takes priority.
- HOLD:
  - res_valid=1 and res_data stable until the handshake.
  - On res_valid & res_ready: res_valid<=0, go to FILL.
  - in_ready=0 during HOLD, so no sample of the next frame is accepted before the result is taken. Earliest in_ready is the cycle after the result handshake.
- A core_done arriving outside WAIT is ignored.
- Latency:
  - Last sample accepted at cycle t: start asserts at t+1, WAIT begins at t+2.
  - core_done seen at cycle d: res_valid asserts at d+1.
- in_ready depends only on state, never combinationally on in_valid. No combinational path from res_ready to in_ready.

Decomposition:
- Shared package maxnet_pkg:
  - typedef sample_t (logic [DW-1:0]).
  - enum seq_state_t {FILL, LAUNCH, WAIT, HOLD}.
  - localparams for default N and DW.
- One natural sub-module: frame_packer. It holds the N x DW slot registers, the write index and the full flag, driven by an accept strobe. The FSM, timeout counter and result register stay in the top level.

Test Plan:
1. Four samples 3,9,17,5 sent back-to-back with in_valid=1 -> x_out={5,17,9,3}; start pulses exactly once, 1 cycle after the 4th accept. Model core returns done=1 with max=17 five cycles later -> res_valid=1 next cycle with res_data=17; frame_cnt=1.
2. Samples sent with gaps (in_valid toggling) -> slot order equals accept order; no start before the 4th accept.
3. res_ready held low for 10 cycles in HOLD -> res_valid and res_data stable; in_ready=0 throughout; core_done pulses in HOLD are ignored; after the handshake, in_ready=1 the next cycle.
4. Core never asserts done -> TIMEOUT cycles after WAIT entry, timeout_err=1, state returns to FILL, no res_valid, frame_cnt unchanged; the next frame then completes normally and timeout_err stays 1.
5. core_done asserted in the exact cycle the timeout fires -> result taken, res_valid=1, timeout_err stays 0.
6. Reset asserted mid-WAIT, then a late core_done -> all outputs at reset values next cycle; the late core_done is ignored; 256 completed frames with CNTW=8 -> frame_cnt wraps to 0.
